// File: rtl/axi_rd_pkg.sv
// Shared definitions for the two-requester AXI read arbiter:
// FSM encodings, ID tag bit position, counter width and RRESP codes.
package axi_rd_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_e;

   // Upstream ID bit that carries the owning requester index
   localparam int TAG_BIT  = 7;
   localparam int REQ_ID_W = 7;
   localparam int AXI_ID_W = 8;

   // Outstanding-burst counter width (holds 0..MAX_OUTS)
   localparam int CNT_W = 3;

   localparam logic [1:0] RRESP_OKAY   = 2'b00;
   localparam logic [1:0] RRESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_rd_arb_if.sv
// AXI-style read channel bundle (AR request + R response) used both for
// the requester side (7-bit IDs) and the shared read interface (8-bit IDs).
// master drives the request and R-ready; slave drives the grant and response.
interface axi_rd_arb_if #(
   parameter int ID_W   = 7,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
) ();

   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [2:0]        arstr;
   logic              arvld;
   logic              arrdy;

   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvld;
   logic              rrdy;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arstr, arvld, rrdy,
      input  arrdy, rid, rdata, rresp, rlast, rvld
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arstr, arvld, rrdy,
      output arrdy, rid, rdata, rresp, rlast, rvld
   );

endinterface

// File: rtl/outs_cnt.sv
// Saturating up/down counter of outstanding read bursts for one requester.
// inc and dec together leave the count unchanged; a lone dec at zero holds
// the count at zero and raises underflow for that cycle.
module outs_cnt
   import axi_rd_pkg::*;
#(
   parameter int MAX_OUTS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero,
   output logic             full,
   output logic             underflow
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTS);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);
   assign full = (cnt_q >= MAX_C);

   // Next count and underflow detection
   always_comb begin
      cnt_d     = cnt_q;
      underflow = 1'b0;
      if (inc && !dec) begin
         if (!full) cnt_d = cnt_q + 3'd1;
      end else if (dec && !inc) begin
         if (zero) underflow = 1'b1;
         else      cnt_d     = cnt_q - 3'd1;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/axi_rd_arb.sv
// Two-requester read arbiter sharing one AXI read interface.
// Requester 0 = LSU, requester 1 = weight/feature prefetch engine.
// Grants one request at a time, registers it toward the read interface with
// the owner index in ID bit 7, routes R beats back by that tag, and throttles
// each requester at MAX_OUTS outstanding bursts.
// Build option: AXI_RD_ARB_PRIO_EN selects fixed priority (requester 0 wins
// ties) instead of the default round-robin.
module axi_rd_arb
   import axi_rd_pkg::*;
#(
   parameter int MAX_OUTS = 4,
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   axi_rd_arb_if.slave   r0,
   axi_rd_arb_if.slave   r1,
   axi_rd_arb_if.master  axi,
   output logic          arb_err
);

   state_e            state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;   // requester preferred on a tie
   logic [7:0]        arid_q, arid_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [7:0]        arlen_q, arlen_d;
   logic [2:0]        arsize_q, arsize_d;
   logic [1:0]        arburst_q, arburst_d;
   logic [2:0]        arstr_q, arstr_d;
   logic              err_q, err_d;

   logic              elig0, elig1, win;
   logic              inc0, inc1, dec0, dec1;
   logic              own, r_last_hs;
   logic [CNT_W-1:0]  cnt0, cnt1;
   logic              zero0, zero1, full0, full1, uf0, uf1;
   logic [DATA_W-1:0] rdata_fan;
   logic              unused_cnt;

   assign elig0 = r0.arvld & ~full0;
   assign elig1 = r1.arvld & ~full1;

   // Grant selection, request latching and issue handshake
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      arid_d    = arid_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      arburst_d = arburst_q;
      arstr_d   = arstr_q;
      r0.arrdy  = 1'b0;
      r1.arrdy  = 1'b0;
      inc0      = 1'b0;
      inc1      = 1'b0;
      win       = 1'b0;
      case (state_q)
         IDLE: begin
            if (elig0 || elig1) begin
`ifdef AXI_RD_ARB_PRIO_EN
               win = ~elig0;
`else
               win = (elig0 && elig1) ? rr_ptr_q : elig1;
               rr_ptr_d = ~win;
`endif
               r0.arrdy  = ~win;
               r1.arrdy  = win;
               arid_d    = win ? {1'b1, r1.arid} : {1'b0, r0.arid};
               araddr_d  = win ? r1.araddr  : r0.araddr;
               arlen_d   = win ? r1.arlen   : r0.arlen;
               arsize_d  = win ? r1.arsize  : r0.arsize;
               arburst_d = win ? r1.arburst : r0.arburst;
               arstr_d   = win ? r1.arstr   : r0.arstr;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (axi.arrdy) begin
               inc0    = ~arid_q[TAG_BIT];
               inc1    = arid_q[TAG_BIT];
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Arbiter state and registered request fields
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= 1'b0;
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
         arstr_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         arid_q    <= arid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arburst_q <= arburst_d;
         arstr_q   <= arstr_d;
         err_q     <= err_d;
      end
   end

   assign axi.arvld   = (state_q == ISSUE);
   assign axi.arid    = arid_q;
   assign axi.araddr  = araddr_q;
   assign axi.arlen   = arlen_q;
   assign axi.arsize  = arsize_q;
   assign axi.arburst = arburst_q;
   assign axi.arstr   = arstr_q;

   // Response routing is combinational: the tag bit selects the owner
   assign own       = axi.rid[TAG_BIT];
   assign rdata_fan = axi.rdata;
   assign r0.rvld   = axi.rvld & ~own;
   assign r1.rvld   = axi.rvld & own;
   assign r0.rid    = axi.rid[REQ_ID_W-1:0];
   assign r1.rid    = axi.rid[REQ_ID_W-1:0];
   assign r0.rdata  = rdata_fan;
   assign r1.rdata  = rdata_fan;
   assign r0.rresp  = axi.rresp;
   assign r1.rresp  = axi.rresp;
   assign r0.rlast  = axi.rlast;
   assign r1.rlast  = axi.rlast;
   assign axi.rrdy  = own ? r1.rrdy : r0.rrdy;

   assign r_last_hs = axi.rvld & axi.rrdy & axi.rlast;
   assign dec0      = r_last_hs & ~own;
   assign dec1      = r_last_hs & own;

   // Sticky error: a burst completed for a requester with nothing outstanding
   always_comb begin
      err_d = err_q | uf0 | uf1;
   end

   assign arb_err = err_q;

   outs_cnt #(.MAX_OUTS(MAX_OUTS)) u_cnt0 (
      .clk(clk), .rst_n(rst_n), .inc(inc0), .dec(dec0),
      .cnt(cnt0), .zero(zero0), .full(full0), .underflow(uf0)
   );

   outs_cnt #(.MAX_OUTS(MAX_OUTS)) u_cnt1 (
      .clk(clk), .rst_n(rst_n), .inc(inc1), .dec(dec1),
      .cnt(cnt1), .zero(zero1), .full(full1), .underflow(uf1)
   );

   assign unused_cnt = ^{cnt0, cnt1, zero0, zero1};

endmodule
